// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the systolic array sequencer.
package systolic_pkg;

  localparam int unsigned ArraySize = 4;
  localparam int unsigned DataWidth = 16;
  localparam int unsigned AccWidth  = 32;
  localparam int unsigned IdxWidth  = $clog2(ArraySize);

  typedef enum logic [1:0] {
    StIdle,
    StLoadW,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata reads zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer feeding a 4x4 systolic array: weight load, credit-limited activation issue,
// and buffered result return.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = ArraySize,
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned ACC_WIDTH  = AccWidth,
  parameter int unsigned RES_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             reload_w,
  input  logic [15:0]                      num_vec,
  output logic                             busy,
  output logic                             done,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [DATA_WIDTH-1:0]            w_data,
  input  logic                             a_valid,
  output logic                             a_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_data,
  output logic                             r_valid,
  input  logic                             r_ready,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  r_data,
  output logic                             arr_load_weight,
  output logic [$clog2(ARRAY_SIZE)-1:0]    arr_weight_row,
  output logic [$clog2(ARRAY_SIZE)-1:0]    arr_weight_col,
  output logic [DATA_WIDTH-1:0]            arr_weight_data,
  output logic                             arr_valid_in,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] arr_act_in,
  input  logic                             arr_valid_out,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  arr_result_out,
  output logic                             overflow
);

  localparam int unsigned IW = $clog2(ARRAY_SIZE);
  localparam int unsigned WW = $clog2(ARRAY_SIZE * ARRAY_SIZE);
  localparam int unsigned OW = $clog2(RES_DEPTH) + 1;
  localparam int unsigned VW = ARRAY_SIZE * DATA_WIDTH;
  localparam int unsigned RW = ARRAY_SIZE * ACC_WIDTH;
  localparam logic [WW-1:0] WLast = WW'(ARRAY_SIZE * ARRAY_SIZE - 1);

  state_e                state_q, state_d;
  logic [15:0]           num_vec_q, num_vec_d;
  logic [15:0]           issued_q, issued_d;
  logic [WW-1:0]         widx_q, widx_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;
  logic                  arr_load_weight_q, arr_load_weight_d;
  logic [IW-1:0]         arr_weight_row_q, arr_weight_row_d;
  logic [IW-1:0]         arr_weight_col_q, arr_weight_col_d;
  logic [DATA_WIDTH-1:0] arr_weight_data_q, arr_weight_data_d;
  logic                  arr_valid_in_q, arr_valid_in_d;
  logic [VW-1:0]         arr_act_in_q, arr_act_in_d;

  logic          w_hs, a_hs, r_hs, occ_dec;
  logic          res_full, res_empty;
  logic [OW-1:0] unused_res_count;

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (arr_valid_out),
    .pop   (r_ready),
    .wdata (arr_result_out),
    .rdata (r_data),
    .full  (res_full),
    .empty (res_empty),
    .count (unused_res_count)
  );

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign w_ready = (state_q == StLoadW);
  // Credit check: never issue more vectors than the result FIFO can absorb.
  assign a_ready = (state_q == StRun) && (issued_q < num_vec_q) && (occ_q < OW'(RES_DEPTH));
  assign r_valid = !res_empty;

  assign w_hs    = w_valid && w_ready;
  assign a_hs    = a_valid && a_ready;
  assign r_hs    = r_valid && r_ready;
  // Results left over from an abandoned job may be popped after reset; keep occ from wrapping.
  assign occ_dec = r_hs && (occ_q != '0);

  assign overflow        = overflow_q;
  assign arr_load_weight = arr_load_weight_q;
  assign arr_weight_row  = arr_weight_row_q;
  assign arr_weight_col  = arr_weight_col_q;
  assign arr_weight_data = arr_weight_data_q;
  assign arr_valid_in    = arr_valid_in_q;
  assign arr_act_in      = arr_act_in_q;

  always_comb begin
    state_d           = state_q;
    num_vec_d         = num_vec_q;
    issued_d          = issued_q;
    widx_d            = widx_q;
    done_d            = 1'b0;
    arr_load_weight_d = 1'b0;
    arr_weight_row_d  = arr_weight_row_q;
    arr_weight_col_d  = arr_weight_col_q;
    arr_weight_data_d = arr_weight_data_q;
    arr_valid_in_d    = 1'b0;
    arr_act_in_d      = arr_act_in_q;
    overflow_d        = overflow_q | (arr_valid_out && res_full && !r_hs);

    case ({a_hs, occ_dec})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_vec_d = num_vec;
          issued_d  = '0;
          widx_d    = '0;
          state_d   = reload_w ? StLoadW : StRun;
        end
      end
      StLoadW: begin
        if (w_hs) begin
          arr_load_weight_d = 1'b1;
          arr_weight_row_d  = IW'(32'(widx_q) / ARRAY_SIZE);
          arr_weight_col_d  = IW'(32'(widx_q) % ARRAY_SIZE);
          arr_weight_data_d = w_data;
          if (widx_q == WLast) begin
            widx_d  = '0;
            state_d = StRun;
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (a_hs) begin
          arr_valid_in_d = 1'b1;
          arr_act_in_d   = a_data;
          issued_d       = issued_q + 1'b1;
        end
        if (issued_d >= num_vec_q) state_d = StDrain;
      end
      StDrain: begin
        // Looking at occ_d lets done follow the final pop by one cycle.
        if (occ_d == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      num_vec_q         <= '0;
      issued_q          <= '0;
      widx_q            <= '0;
      occ_q             <= '0;
      done_q            <= 1'b0;
      overflow_q        <= 1'b0;
      arr_load_weight_q <= 1'b0;
      arr_weight_row_q  <= '0;
      arr_weight_col_q  <= '0;
      arr_weight_data_q <= '0;
      arr_valid_in_q    <= 1'b0;
      arr_act_in_q      <= '0;
    end else begin
      state_q           <= state_d;
      num_vec_q         <= num_vec_d;
      issued_q          <= issued_d;
      widx_q            <= widx_d;
      occ_q             <= occ_d;
      done_q            <= done_d;
      overflow_q        <= overflow_d;
      arr_load_weight_q <= arr_load_weight_d;
      arr_weight_row_q  <= arr_weight_row_d;
      arr_weight_col_q  <= arr_weight_col_d;
      arr_weight_data_q <= arr_weight_data_d;
      arr_valid_in_q    <= arr_valid_in_d;
      arr_act_in_q      <= arr_act_in_d;
    end
  end

endmodule
